// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with a valid/ready
// handshake on both ends, bubble collapse, synchronous flush and a
// registered occupancy count.
module dff_pipe #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       DEPTH       = 3,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];

    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_next;

    // Ready chain: a stage can load if it is empty or anything downstream
    // of it (including the consumer) can make room this cycle. Built as a
    // running OR from the output end so no signal feeds back on itself.
    always_comb begin
        logic acc;
        acc = out_ready;
        r   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            acc  = acc | ~v[i];
            r[i] = acc;
        end
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    // Handshake outputs; flush blocks both transfers in its cycle.
    always_comb begin
        in_ready  = r[0] & ~flush & ~reset;
        out_valid = v[DEPTH-1] & ~flush;
        out_data  = d[DEPTH-1];
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
    end

    // Stage valid bits: cleared by reset or flush, otherwise follow the source when ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r[i]) begin
                    v[i] <= src_v[i];
                end
            end
        end
    end

    // Stage data: loads only valid source data so idle inputs are never captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                d[i] <= RESET_VALUE;
            end
        end else if (!flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r[i] && src_v[i]) begin
                    d[i] <= src_d[i];
                end
            end
        end
    end

    // Occupancy update: net of one possible input and one possible output transfer.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (in_xfer && !out_xfer) begin
            count_next = count + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised, elastic register pipeline: WIDTH-bit data travels through DEPTH flop stages, each stage with its own valid bit.
- Valid/ready handshake on both sides; bubbles collapse, so an empty stage accepts data even while downstream is stalled.
- Provides synchronous flush and an occupancy count.
- Generic retiming/delay building block for datapaths that previously used bare async-reset D flip-flops.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- RESET_VALUE, 0, value loaded into every data stage on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- out_valid  output  1  last stage holds valid data.
- out_data  output  WIDTH  last stage data.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side). Per stage: v[i] (valid) and d[i] (data).
- Reset (async assert, sampled-free): all v[i]=0, all d[i]=RESET_VALUE, count=0, out_valid=0, out_data=RESET_VALUE. in_ready=1 once reset is low.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = ~v[i] | r[i+1].
  - in_ready = r[0] & ~flush.
  - in_ready depends combinationally on out_ready; this path is intentional.
- Stage update on a clock edge when flush=0:
  - If r[i] holds, then v[i] <= src_valid and d[i] <= src_data, where src is (in_valid, in_data) for i=0, else (v[i-1], d[i-1]).
  - Data loads only when src_valid=1; otherwise d[i] holds its old value.
  - If r[i] does not hold, the stage holds both v[i] and d[i].
- out_valid = v[DEPTH-1] & ~flush; out_data = d[DEPTH-1].
- Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready. Each is counted at most once per cycle.
- Latency: DEPTH cycles from input transfer to out_valid, with no stalls and an empty pipe.
- Throughput: 1 item/cycle sustained while out_ready=1.
- Capacity: DEPTH items. With out_ready=0, in_ready falls only after all DEPTH stages are valid.
- Ordering: strictly FIFO. No item is dropped or duplicated except by flush or reset.
- count:
  - Registered; equals the number of set v[i] after each edge.
  - Updates as count + in_xfer - out_xfer, so simultaneous in/out leaves it unchanged.
  - Range 0..DEPTH, never wraps.
- flush=1 (synchronous):
  - in_ready=0 and out_valid=0 in that cycle; no transfers occur.
  - Next edge: all v[i]=0, count=0.
  - d[i] retains its value (data is not cleared).
- flush and reset together: reset dominates.
- Reset asserted mid-stream: immediate asynchronous clear of outputs as above; in-flight items are lost.
- DEPTH=1: a single stage. in_ready = ~v[0] | out_ready. Full throughput is still possible.
- X-safety: in_data is never captured when in_valid=0.

Test Plan:
- Streaming (DEPTH=3, WIDTH=8): reset, then drive in_valid=1 with data 0x01,0x02,0x03,... every cycle, out_ready=1 -> first out_valid 3 cycles after first transfer, out_data 0x01,0x02,... one per cycle, count steady at 3, in_ready=1 throughout.
- Backpressure fill: out_ready=0, push 0xA0..0xA4 -> exactly 3 accepted (0xA0..0xA2), in_ready=0 with count=3, out_data=0xA0. Then raise out_ready for 1 cycle -> 0xA0 leaves, 0xA3 accepted the same cycle, count stays 3.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, with out_ready=0 -> both stages packed at output end, count=2, in_ready=1. Release -> 0x11 then 0x22 on consecutive cycles.
- Flush: with count=3 and out_ready=1, pulse flush for 1 cycle -> no output transfer that cycle, in_ready=0 and out_valid=0, count=0 next cycle. A new push of 0x5A appears DEPTH cycles later, uncorrupted.
- Async reset mid-stream: assert reset between clock edges while count=2 -> out_valid=0, count=0, out_data=RESET_VALUE immediately without a clock edge. Release -> in_ready=1 and normal operation resumes.
- DEPTH=1, RESET_VALUE=8'hFF: after reset out_data=0xFF. Random in_valid/out_ready for 1000 cycles -> scoreboard shows exact in-order delivery and count always in 0..1.
